// File: rtl/block_positions_table.sv
// block_positions_table: looks up a block record in an external block-table BRAM
// and computes the block's current depth from song time. It also scans the whole
// table on request so the renderer can gather every block for one frame.
module block_positions_table #(
  parameter int NUM_BLOCKS  = 64,
  parameter int IDX_W       = 8,
  parameter int TIME_W      = 18,
  parameter int Z_SPAWN     = 3000,
  parameter int Z_SPEED     = 20,
  parameter int HIT_WINDOW  = 10,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_valid,
  input  logic [IDX_W-1:0]  req_index,
  input  logic [TIME_W-1:0] curr_time,
  output logic              req_ready,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              scan_done,
  output logic [IDX_W-1:0]  mem_addr,
  input  logic [45:0]       mem_data,
  output logic              out_valid,
  output logic              block_visible,
  output logic [IDX_W-1:0]  curr_block_index_out,
  output logic [11:0]       block_x,
  output logic [11:0]       block_y,
  output logic [13:0]       block_z,
  output logic              block_color,
  output logic [2:0]        block_direction
);

  // Last tick (relative to spawn) at which a block is still shown.
  localparam int T_ARR  = (Z_SPAWN + Z_SPEED - 1) / Z_SPEED + HIT_WINDOW;
  localparam int TRAV_W = TIME_W + 8;
  localparam int LAT    = MEM_LATENCY;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [TRAV_W-1:0] SPEED_T  = TRAV_W'(Z_SPEED);
  localparam logic [TRAV_W-1:0] SPAWN_T  = TRAV_W'(Z_SPAWN);
  localparam logic [13:0]       SPAWN_Z  = 14'(Z_SPAWN);
  localparam logic [TIME_W-1:0] T_ARR_T  = TIME_W'(T_ARR);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  // Depth remaining after travelling 'travel' units, clamped at zero.
  function automatic logic [13:0] sat_depth(input logic [TRAV_W-1:0] travel);
    if (travel < SPAWN_T) return 14'(SPAWN_T - travel);
    return 14'd0;
  endfunction

  // A spawned block stays visible until the hit window after arrival closes.
  function automatic logic in_window(input logic [TIME_W-1:0] elapsed);
    return (elapsed <= T_ARR_T);
  endfunction

  // Control state
  state_t              state_q, state_d;
  logic [IDX_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [TIME_W-1:0]   scan_time_q, scan_time_d;
  logic [IDX_W-1:0]    mem_addr_q, mem_addr_d;

  // Lookup being issued this cycle
  logic                iss_vld;
  logic                iss_last;
  logic                iss_inr;
  logic [IDX_W-1:0]    iss_idx;
  logic [TIME_W-1:0]   iss_time;

  // Sideband delay line matching the BRAM read latency
  logic                dly_vld_q  [LAT];
  logic                dly_vld_d  [LAT];
  logic                dly_last_q [LAT];
  logic                dly_last_d [LAT];
  logic                dly_inr_q  [LAT];
  logic                dly_inr_d  [LAT];
  logic [IDX_W-1:0]    dly_idx_q  [LAT];
  logic [IDX_W-1:0]    dly_idx_d  [LAT];
  logic [TIME_W-1:0]   dly_time_q [LAT];
  logic [TIME_W-1:0]   dly_time_d [LAT];

  // Stage p1: BRAM word captured, elapsed time formed
  logic                vld_p1_q, vld_p1_d;
  logic                last_p1_q, last_p1_d;
  logic                inr_p1_q, inr_p1_d;
  logic                before_p1_q, before_p1_d;
  logic [IDX_W-1:0]    idx_p1_q, idx_p1_d;
  logic [TIME_W-1:0]   elapsed_p1_q, elapsed_p1_d;
  logic [11:0]         x_p1_q, x_p1_d;
  logic [11:0]         y_p1_q, y_p1_d;
  logic                col_p1_q, col_p1_d;
  logic [2:0]          dir_p1_q, dir_p1_d;

  // Stage p2: travel distance registered
  logic                vld_p2_q, vld_p2_d;
  logic                last_p2_q, last_p2_d;
  logic                inr_p2_q, inr_p2_d;
  logic                before_p2_q, before_p2_d;
  logic                vis_p2_q, vis_p2_d;
  logic [IDX_W-1:0]    idx_p2_q, idx_p2_d;
  logic [TRAV_W-1:0]   travel_p2_q, travel_p2_d;
  logic [11:0]         x_p2_q, x_p2_d;
  logic [11:0]         y_p2_q, y_p2_d;
  logic                col_p2_q, col_p2_d;
  logic [2:0]          dir_p2_q, dir_p2_d;

  // Output registers
  logic                out_valid_q, out_valid_d;
  logic                scan_done_q, scan_done_d;
  logic                vis_q, vis_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [11:0]         x_q, x_d;
  logic [11:0]         y_q, y_d;
  logic [13:0]         z_q, z_d;
  logic                col_q, col_d;
  logic [2:0]          dir_q, dir_d;

  logic [TIME_W-1:0]   mem_spawn;

  assign mem_spawn = TIME_W'(mem_data[45:28]);
  assign iss_inr   = (iss_idx <= LAST_IDX);

  // Scan sequencing and selection of the lookup issued this cycle
  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    scan_time_d = scan_time_q;
    iss_vld     = 1'b0;
    iss_last    = 1'b0;
    iss_idx     = req_index;
    iss_time    = curr_time;
    unique case (state_q)
      S_IDLE: begin
        // A scan start takes priority; a coincident request is dropped.
        if (scan_start) begin
          iss_vld     = 1'b1;
          iss_idx     = '0;
          iss_last    = (LAST_IDX == '0);
          scan_time_d = curr_time;
          scan_cnt_d  = IDX_W'(1);
          state_d     = (LAST_IDX == '0) ? S_DRAIN : S_SCAN;
        end else if (req_valid) begin
          iss_vld = 1'b1;
        end
      end
      S_SCAN: begin
        iss_vld  = 1'b1;
        iss_idx  = scan_cnt_q;
        iss_time = scan_time_q;
        if (scan_cnt_q == LAST_IDX) begin
          iss_last = 1'b1;
          state_d  = S_DRAIN;
        end else begin
          scan_cnt_d = scan_cnt_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (scan_done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values for every pipeline stage
  always_comb begin
    // Issue: out-of-range indices leave the BRAM address untouched.
    mem_addr_d    = (iss_vld && iss_inr) ? iss_idx : mem_addr_q;
    dly_vld_d[0]  = iss_vld;
    dly_last_d[0] = iss_last;
    dly_inr_d[0]  = iss_inr;
    dly_idx_d[0]  = iss_idx;
    dly_time_d[0] = iss_time;
    for (int k = 1; k < LAT; k++) begin
      dly_vld_d[k]  = dly_vld_q[k-1];
      dly_last_d[k] = dly_last_q[k-1];
      dly_inr_d[k]  = dly_inr_q[k-1];
      dly_idx_d[k]  = dly_idx_q[k-1];
      dly_time_d[k] = dly_time_q[k-1];
    end

    // p1: BRAM data is valid alongside the last delay-line entry.
    vld_p1_d     = dly_vld_q[LAT-1];
    last_p1_d    = dly_vld_q[LAT-1] & dly_last_q[LAT-1];
    inr_p1_d     = dly_inr_q[LAT-1];
    idx_p1_d     = dly_idx_q[LAT-1];
    before_p1_d  = (dly_time_q[LAT-1] < mem_spawn);
    elapsed_p1_d = dly_time_q[LAT-1] - mem_spawn;
    x_p1_d       = mem_data[27:16];
    y_p1_d       = mem_data[15:4];
    col_p1_d     = mem_data[3];
    dir_p1_d     = mem_data[2:0];

    // p2: full-width travel so late lookups cannot wrap back into view.
    vld_p2_d     = vld_p1_q;
    last_p2_d    = last_p1_q;
    inr_p2_d     = inr_p1_q;
    before_p2_d  = before_p1_q;
    vis_p2_d     = inr_p1_q & ~before_p1_q & in_window(elapsed_p1_q);
    idx_p2_d     = idx_p1_q;
    travel_p2_d  = {8'd0, elapsed_p1_q} * SPEED_T;
    x_p2_d       = x_p1_q;
    y_p2_d       = y_p1_q;
    col_p2_d     = col_p1_q;
    dir_p2_d     = dir_p1_q;

    // Output: unaddressed (out-of-range) lookups report all-zero fields.
    out_valid_d  = vld_p2_q;
    scan_done_d  = vld_p2_q & last_p2_q;
    vis_d        = vis_p2_q;
    idx_d        = idx_p2_q;
    x_d          = inr_p2_q ? x_p2_q   : 12'd0;
    y_d          = inr_p2_q ? y_p2_q   : 12'd0;
    col_d        = inr_p2_q ? col_p2_q : 1'b0;
    dir_d        = inr_p2_q ? dir_p2_q : 3'd0;
    if (!inr_p2_q)        z_d = 14'd0;
    else if (before_p2_q) z_d = SPAWN_Z;
    else                  z_d = sat_depth(travel_p2_q);
  end

  // Control, valid chain and output registers (cleared by reset)
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      scan_cnt_q  <= '0;
      mem_addr_q  <= '0;
      for (int k = 0; k < LAT; k++) begin
        dly_vld_q[k]  <= 1'b0;
        dly_last_q[k] <= 1'b0;
      end
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      vld_p2_q    <= 1'b0;
      last_p2_q   <= 1'b0;
      out_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
      vis_q       <= 1'b0;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      col_q       <= 1'b0;
      dir_q       <= '0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      mem_addr_q  <= mem_addr_d;
      for (int k = 0; k < LAT; k++) begin
        dly_vld_q[k]  <= dly_vld_d[k];
        dly_last_q[k] <= dly_last_d[k];
      end
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
      vld_p2_q    <= vld_p2_d;
      last_p2_q   <= last_p2_d;
      out_valid_q <= out_valid_d;
      scan_done_q <= scan_done_d;
      vis_q       <= vis_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      col_q       <= col_d;
      dir_q       <= dir_d;
    end
  end

  // Data-only pipeline registers (qualified by the valid chain, no reset)
  always_ff @(posedge clk_in) begin
    scan_time_q <= scan_time_d;
    for (int k = 0; k < LAT; k++) begin
      dly_inr_q[k]  <= dly_inr_d[k];
      dly_idx_q[k]  <= dly_idx_d[k];
      dly_time_q[k] <= dly_time_d[k];
    end
    inr_p1_q     <= inr_p1_d;
    before_p1_q  <= before_p1_d;
    idx_p1_q     <= idx_p1_d;
    elapsed_p1_q <= elapsed_p1_d;
    x_p1_q       <= x_p1_d;
    y_p1_q       <= y_p1_d;
    col_p1_q     <= col_p1_d;
    dir_p1_q     <= dir_p1_d;
    inr_p2_q     <= inr_p2_d;
    before_p2_q  <= before_p2_d;
    vis_p2_q     <= vis_p2_d;
    idx_p2_q     <= idx_p2_d;
    travel_p2_q  <= travel_p2_d;
    x_p2_q       <= x_p2_d;
    y_p2_q       <= y_p2_d;
    col_p2_q     <= col_p2_d;
    dir_p2_q     <= dir_p2_d;
  end

  assign req_ready            = (state_q == S_IDLE) & ~rst_in;
  assign scan_busy            = (state_q != S_IDLE);
  assign scan_done            = scan_done_q;
  assign mem_addr             = mem_addr_q;
  assign out_valid            = out_valid_q;
  assign block_visible        = vis_q;
  assign curr_block_index_out = idx_q;
  assign block_x              = x_q;
  assign block_y              = y_q;
  assign block_z              = z_q;
  assign block_color          = col_q;
  assign block_direction      = dir_q;

endmodule

// File: tb/tb_block_positions_table.sv
// Bench for block_positions_table: directed vector table, randomized lookups
// against a reference model, full scan and reset-during-scan sequences.
module tb_block_positions_table;

  localparam int NB      = 64;
  localparam int ZSPAWN  = 3000;
  localparam int ZSPEED  = 20;
  localparam int HITW    = 10;
  localparam int LATENCY = 4;
  localparam int T_ARR   = (ZSPAWN + ZSPEED - 1) / ZSPEED + HITW;
  localparam int NVEC    = 12;

  typedef struct {
    int idx; int vis; int x; int y; int z; int c; int d; int done; int due;
  } exp_t;

  typedef struct {
    int idx; int t; int vis; int x; int y; int z; int c; int d;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [7:0]  req_index;
  logic [17:0] curr_time;
  logic        req_ready;
  logic        scan_start;
  logic        scan_busy;
  logic        scan_done;
  logic [7:0]  mem_addr;
  logic [45:0] mem_data;
  logic        out_valid;
  logic        block_visible;
  logic [7:0]  curr_block_index_out;
  logic [11:0] block_x;
  logic [11:0] block_y;
  logic [13:0] block_z;
  logic        block_color;
  logic [2:0]  block_direction;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int spawn_t [NB];
  int xs [NB];
  int ys [NB];
  int cs [NB];
  int ds [NB];
  logic [45:0] mem [0:255];
  logic [45:0] mem_q;
  exp_t expq [$];
  exp_t mon_e;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: registered read, data sampled by the DUT one edge later
  always @(posedge clk) mem_q <= mem[mem_addr];
  assign mem_data = mem_q;

  block_positions_table dut (
    .clk_in(clk), .rst_in(rst), .req_valid(req_valid), .req_index(req_index),
    .curr_time(curr_time), .req_ready(req_ready), .scan_start(scan_start),
    .scan_busy(scan_busy), .scan_done(scan_done), .mem_addr(mem_addr),
    .mem_data(mem_data), .out_valid(out_valid), .block_visible(block_visible),
    .curr_block_index_out(curr_block_index_out), .block_x(block_x),
    .block_y(block_y), .block_z(block_z), .block_color(block_color),
    .block_direction(block_direction)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: what the renderer should see for block idx at song time t.
  function automatic exp_t model(input int idx, input int t);
    exp_t e;
    int el;
    int travel;
    e = '{idx: idx, vis: 0, x: 0, y: 0, z: 0, c: 0, d: 0, done: 0, due: 0};
    if (idx < NB) begin
      e.x = xs[idx]; e.y = ys[idx]; e.c = cs[idx]; e.d = ds[idx];
      if (t < spawn_t[idx]) begin
        e.z = ZSPAWN;
      end else begin
        el     = t - spawn_t[idx];
        travel = el * ZSPEED;
        e.z    = (travel >= ZSPAWN) ? 0 : ZSPAWN - travel;
        e.vis  = (el <= T_ARR) ? 1 : 0;
      end
    end
    return e;
  endfunction

  task automatic push_exp(input exp_t e, input int due, input int done);
    exp_t n;
    n = e;
    n.due = due;
    n.done = done;
    expq.push_back(n);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, expq.size());
    end
  endtask

  // Scoreboard: every out_valid must match the oldest expectation, on time
  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_result: idx=%0d due cycle %0d, none by cycle %0d",
               expq[0].idx, expq[0].due, cyc);
      expq.delete(0);
    end
    if (out_valid) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: idx=%0d at cycle %0d, required no result",
                 curr_block_index_out, cyc);
      end else begin
        mon_e = expq.pop_front();
        if (curr_block_index_out !== 8'(mon_e.idx) || block_visible !== 1'(mon_e.vis) ||
            block_x !== 12'(mon_e.x) || block_y !== 12'(mon_e.y) ||
            block_z !== 14'(mon_e.z) || block_color !== 1'(mon_e.c) ||
            block_direction !== 3'(mon_e.d) || scan_done !== 1'(mon_e.done) ||
            cyc != mon_e.due) begin
          errors++;
          $display("FAIL result: got idx=%0d vis=%0d x=%0d y=%0d z=%0d c=%0d d=%0d done=%0d cyc=%0d, required idx=%0d vis=%0d x=%0d y=%0d z=%0d c=%0d d=%0d done=%0d cyc=%0d",
                   curr_block_index_out, block_visible, block_x, block_y, block_z,
                   block_color, block_direction, scan_done, cyc,
                   mon_e.idx, mon_e.vis, mon_e.x, mon_e.y, mon_e.z, mon_e.c, mon_e.d,
                   mon_e.done, mon_e.due);
        end
      end
    end else if (scan_done) begin
      checks++;
      errors++;
      $display("FAIL scan_done_without_valid: got scan_done=1 at cycle %0d, required 0", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int idx;
    int t;
    int sp;
    exp_t e;

    rst = 1'b1; req_valid = 1'b0; req_index = '0; curr_time = '0; scan_start = 1'b0;

    for (int i = 0; i < NB; i++) begin
      spawn_t[i] = $urandom_range(0, 2000);
      xs[i] = $urandom_range(0, 4095);
      ys[i] = $urandom_range(0, 4095);
      cs[i] = $urandom_range(0, 1);
      ds[i] = $urandom_range(0, 7);
    end
    spawn_t[5] = 100;  xs[5] = 200;  ys[5] = 150;  cs[5] = 1; ds[5] = 2;
    spawn_t[0] = 0;    xs[0] = 10;   ys[0] = 20;   cs[0] = 0; ds[0] = 0;
    spawn_t[1] = 1000; xs[1] = 11;   ys[1] = 21;   cs[1] = 1; ds[1] = 7;
    spawn_t[2] = 400;  xs[2] = 4095; ys[2] = 4095; cs[2] = 1; ds[2] = 5;
    for (int i = 0; i < 256; i++) begin
      if (i < NB) mem[i] = {18'(spawn_t[i]), 12'(xs[i]), 12'(ys[i]), 1'(cs[i]), 3'(ds[i])};
      else        mem[i] = 46'({$urandom(), $urandom()});
    end

    // idx, time, vis, x, y, z, color, dir
    vecs[0]  = '{5,   120, 1, 200,  150,  2600, 1, 2};
    vecs[1]  = '{5,   250, 1, 200,  150,  0,    1, 2};
    vecs[2]  = '{5,   260, 1, 200,  150,  0,    1, 2};
    vecs[3]  = '{5,   261, 0, 200,  150,  0,    1, 2};
    vecs[4]  = '{5,   50,  0, 200,  150,  3000, 1, 2};
    vecs[5]  = '{70,  120, 0, 0,    0,    0,    0, 0};
    vecs[6]  = '{5,   100, 1, 200,  150,  3000, 1, 2};
    vecs[7]  = '{5,   249, 1, 200,  150,  20,   1, 2};
    vecs[8]  = '{0,   10,  1, 10,   20,   2800, 0, 0};
    vecs[9]  = '{1,   10,  0, 11,   21,   3000, 1, 7};
    vecs[10] = '{2,   500, 1, 4095, 4095, 1000, 1, 5};
    vecs[11] = '{255, 0,   0, 0,    0,    0,    0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({out_valid, scan_done, scan_busy, block_visible, block_color,
                              block_direction, block_x, block_y, block_z,
                              curr_block_index_out, mem_addr}), 64'd0);
    chk("req_ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("req_ready_after_release", 64'(req_ready), 64'd1);
    chk("scan_busy_after_release", 64'(scan_busy), 64'd0);

    // Directed vectors, issued back to back
    for (int i = 0; i < NVEC; i++) begin
      req_valid = 1'b1;
      req_index = 8'(vecs[i].idx);
      curr_time = 18'(vecs[i].t);
      e = '{idx: vecs[i].idx, vis: vecs[i].vis, x: vecs[i].x, y: vecs[i].y, z: vecs[i].z,
            c: vecs[i].c, d: vecs[i].d, done: 0, due: 0};
      push_exp(e, cyc + 1 + LATENCY, 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain("table");

    // Randomized lookups against the model
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 9) < 7) begin
        idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(64, 255)) : int'($urandom_range(0, 63));
        sp  = spawn_t[idx % NB];
        case ($urandom_range(0, 3))
          0:       t = sp + int'($urandom_range(0, 200));
          1:       t = $urandom_range(0, 3500);
          2:       t = 262143 - int'($urandom_range(0, 50));
          default: t = (sp > 0) ? sp - 1 : 0;
        endcase
        req_valid = 1'b1;
        req_index = 8'(idx);
        curr_time = 18'(t);
        push_exp(model(idx, t), cyc + 1 + LATENCY, 0);
      end else begin
        req_valid = 1'b0;
        curr_time = 18'($urandom_range(0, 4000));
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain("random");

    // Full scan; a coincident request is dropped, requests during the scan ignored
    @(posedge clk); #1;
    scan_start = 1'b1;
    req_valid  = 1'b1;
    req_index  = 8'd5;
    curr_time  = 18'd500;
    base = cyc;
    #1;
    chk("req_ready_at_scan_start", 64'(req_ready), 64'd1);
    for (int k = 0; k < NB; k++) push_exp(model(k, 500), base + 1 + LATENCY + k, (k == NB - 1) ? 1 : 0);
    for (int k = 0; k < 90; k++) begin
      @(posedge clk); #1;
      scan_start = (k == 20);
      req_valid  = (cyc < base + 67) && ($urandom_range(0, 1) == 1);
      req_index  = 8'($urandom_range(0, 63));
      curr_time  = 18'($urandom_range(0, 4000));
      if (k == 3) begin
        chk("req_ready_during_scan", 64'(req_ready), 64'd0);
        chk("scan_busy_during_scan", 64'(scan_busy), 64'd1);
      end
      @(negedge clk);
      if (cyc == base + 68) begin
        chk("scan_done_on_last", 64'(scan_done), 64'd1);
        chk("scan_busy_with_done", 64'(scan_busy), 64'd1);
      end
      if (cyc == base + 69) begin
        chk("scan_busy_after_done", 64'(scan_busy), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    scan_start = 1'b0;
    drain("scan");

    // Reset while the scan is at index 30
    @(posedge clk); #1;
    scan_start = 1'b1;
    curr_time  = 18'd700;
    base = cyc;
    for (int k = 0; k < NB; k++) push_exp(model(k, 700), base + 1 + LATENCY + k, (k == NB - 1) ? 1 : 0);
    @(posedge clk); #1;
    scan_start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    while (expq.size() > 0 && expq[expq.size() - 1].due > cyc) expq.delete(expq.size() - 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("req_ready_in_abort_reset", 64'(req_ready), 64'd0);
      if (i > 0) begin
        chk("valid_done_busy_in_reset", 64'({out_valid, scan_done, scan_busy}), 64'd0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("req_ready_after_abort", 64'(req_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_after_abort", 64'({out_valid, scan_done, scan_busy}), 64'd0);
    end

    // Fresh lookup after the abort
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_index = 8'd5;
    curr_time = 18'd120;
    e = '{idx: 5, vis: 1, x: 200, y: 150, z: 2600, c: 1, d: 2, done: 0, due: 0};
    push_exp(e, cyc + 1 + LATENCY, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
